// File: rtl/simple_fifo_if.sv
// Push/pop handshake bundle for simple_fifo: the master drives requests,
// the slave (the FIFO) returns read data and status flags.
interface simple_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] wrdata;
  logic                  wren;
  logic                  rden;
  logic [DATA_WIDTH-1:0] rddata;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output wrdata, wren, rden,
    input  rddata, data_valid, full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  wrdata, wren, rden,
    output rddata, data_valid, full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/simple_fifo.sv
// Single-clock FIFO: register-array storage, binary pointers, occupancy
// counter, registered read data and sticky overflow/underflow flags.
module simple_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  simple_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rddata_q, rddata_d;
  logic                  data_valid_q, data_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full, empty, rd_accept, wr_accept;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A pop frees a slot in the same edge, so a push into a full FIFO is legal
  // only alongside an accepted pop; no bypass exists when empty.
  assign rd_accept = bus.rden && !empty;
  assign wr_accept = bus.wren && (!full || rd_accept);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rddata_d     = rddata_q;
    data_valid_d = rd_accept;
    ovf_d        = ovf_q | (bus.wren && !wr_accept);
    udf_d        = udf_q | (bus.rden && empty);

    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      rddata_d = mem_q[rd_ptr_q];
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rddata_q     <= '0;
      data_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rddata_q     <= rddata_d;
      data_valid_q <= data_valid_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_accept) mem_q[wr_ptr_q] <= bus.wrdata;
  end

  assign bus.rddata        = rddata_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;
endmodule

// File: tb/tb_simple_fifo.sv
// Self-checking bench for simple_fifo: vector table, directed corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_simple_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  simple_fifo_if #(.DATA_WIDTH(DW)) bus ();

  simple_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of stored words plus expected registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_dv, m_ovf, m_udf;

  typedef struct {
    bit            rst;
    bit            we;
    bit            re;
    logic [DW-1:0] wd;
    bit            dv;
    logic [DW-1:0] rd;
    bit            full;
    bit            empty;
    bit            ovf;
    bit            udf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit we, input logic [DW-1:0] wd, input bit re);
    bit full_m, empty_m, rd_acc, wr_acc;
    if (r) begin
      q.delete();
      m_rd = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
      return;
    end
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    rd_acc  = re && !empty_m;
    wr_acc  = we && (!full_m || rd_acc);
    m_dv = rd_acc;
    if (rd_acc) m_rd = q.pop_front();
    if (wr_acc) q.push_back(wd);
    if (we && !wr_acc) m_ovf = 1;
    if (re && empty_m) m_udf = 1;
  endtask

  task automatic step(input bit r, input bit we, input logic [DW-1:0] wd, input bit re);
    rst_n = r; bus.wren = we; bus.wrdata = wd; bus.rden = re;
    model_edge(r, we, wd, re);
    @(posedge clk);
    #1;
    rst_n = 1'b0; bus.wren = 1'b0; bus.rden = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data_valid"}, 32'(bus.data_valid), 32'(m_dv));
    if (m_dv) chk({tag, ".rddata"}, 32'(bus.rddata), 32'(m_rd));
    chk({tag, ".full"},  32'(bus.full),  32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".overflow_err"},  32'(bus.overflow_err),  32'(m_ovf));
    chk({tag, ".underflow_err"}, 32'(bus.underflow_err), 32'(m_udf));
  endtask

  task automatic do_step(input string tag, input bit r, input bit we,
                         input logic [DW-1:0] wd, input bit re);
    step(r, we, wd, re);
    chk_model(tag);
  endtask

  vec_t vt[11];

  initial begin
    rst_n = 1'b1; bus.wren = 1'b0; bus.rden = 1'b0; bus.wrdata = '0;

    // rst we re wd | dv rd full empty ovf udf
    vt[0]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0};
    vt[1]  = '{0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1};
    vt[2]  = '{0, 1, 0, 8'h11, 0, 8'h00, 0, 0, 0, 1};
    vt[3]  = '{0, 1, 0, 8'h22, 0, 8'h00, 0, 0, 0, 1};
    vt[4]  = '{0, 0, 1, 8'h00, 1, 8'h11, 0, 0, 0, 1};
    vt[5]  = '{0, 1, 1, 8'h33, 1, 8'h22, 0, 0, 0, 1};
    vt[6]  = '{0, 0, 0, 8'h00, 0, 8'h22, 0, 0, 0, 1};
    vt[7]  = '{0, 0, 1, 8'h00, 1, 8'h33, 0, 1, 0, 1};
    vt[8]  = '{1, 1, 1, 8'h5A, 0, 8'h00, 0, 1, 0, 0};
    vt[9]  = '{0, 1, 1, 8'h44, 0, 8'h00, 0, 0, 0, 1};
    vt[10] = '{0, 0, 1, 8'h00, 1, 8'h44, 0, 1, 0, 1};

    for (int i = 0; i < 11; i++) begin
      step(vt[i].rst, vt[i].we, vt[i].wd, vt[i].re);
      chk($sformatf("vec%0d.data_valid", i), 32'(bus.data_valid), 32'(vt[i].dv));
      chk($sformatf("vec%0d.rddata", i), 32'(bus.rddata), 32'(vt[i].rd));
      chk($sformatf("vec%0d.full", i), 32'(bus.full), 32'(vt[i].full));
      chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vt[i].empty));
      chk($sformatf("vec%0d.overflow_err", i), 32'(bus.overflow_err), 32'(vt[i].ovf));
      chk($sformatf("vec%0d.underflow_err", i), 32'(bus.underflow_err), 32'(vt[i].udf));
    end

    // Overflow: 33 pushes, the last one is dropped; drain returns 0x00..0x1F.
    do_step("ovf.rst", 1, 0, 0, 0);
    for (int i = 0; i <= DEPTH; i++) do_step("ovf.push", 0, 1, DW'(i), 0);
    chk("ovf.full_after_33", 32'(bus.full), 32'd1);
    chk("ovf.flag", 32'(bus.overflow_err), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      do_step("ovf.drain", 0, 0, 0, 1);
      chk("ovf.drain_data", 32'(bus.rddata), 32'(i));
    end
    do_step("ovf.extra_pop", 0, 0, 0, 1);
    chk("ovf.no_0x20", 32'(bus.data_valid), 32'd0);

    // Wrap-around: 20 in/out, then a full 32 in/out across the pointer wrap.
    do_step("wrap.rst", 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) do_step("wrap.push20", 0, 1, DW'(8'h80 + i), 0);
    for (int i = 0; i < 20; i++) do_step("wrap.pop20", 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) do_step("wrap.push32", 0, 1, DW'(8'hC0 + i), 0);
    chk("wrap.full", 32'(bus.full), 32'd1);

    // Simultaneous push+pop while full keeps it full with no overflow.
    for (int i = 0; i < 4; i++) do_step("simul.full", 0, 1, DW'(8'hE0 + i), 1);
    chk("simul.full_stays", 32'(bus.full), 32'd1);
    chk("simul.no_ovf", 32'(bus.overflow_err), 32'd0);
    for (int i = 0; i < DEPTH; i++) do_step("wrap.pop32", 0, 0, 0, 1);
    chk("wrap.empty", 32'(bus.empty), 32'd1);

    // Reset mid-operation discards contents and clears flags.
    for (int i = 0; i < 10; i++) do_step("midrst.push", 0, 1, DW'(i + 3), 0);
    do_step("midrst.rst", 1, 0, 0, 0);
    chk("midrst.empty", 32'(bus.empty), 32'd1);
    do_step("midrst.pop", 0, 0, 0, 1);
    chk("midrst.udf", 32'(bus.underflow_err), 32'd1);

    // Randomized traffic with occasional resets.
    do_step("rand.rst", 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, we, re;
      int phase;
      phase = (i / 300) % 3;
      r  = ($urandom_range(0, 399) == 0);
      we = (phase == 0) ? ($urandom_range(0, 9) < 8) :
           (phase == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1) == 1;
      re = (phase == 0) ? ($urandom_range(0, 9) < 2) :
           (phase == 1) ? ($urandom_range(0, 9) < 8) : $urandom_range(0, 1) == 1;
      do_step("rand", r, we, DW'($urandom), re);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simple_fifo.md
Name: simple_fifo

Overview:
- Single-clock synchronous FIFO of DEPTH entries, each DATA_WIDTH bits wide.
- A push interface (wren/wrdata) and a pop interface (rden) are backed by a register-array memory with binary read/write pointers and an occupancy counter.
- Read data is registered and qualified by data_valid.
- full and empty status flags are provided, plus sticky overflow and underflow error flags for illegal accesses.

Parameters:
- DATA_WIDTH, 8, width of wrdata/rddata in bits (>=1).
- DEPTH, 32, number of entries. Must be a power of two and >=2. Pointer width is $clog2(DEPTH); count width is $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-high. Reset is applied on the clk rising edge while rst_n==1.
- wrdata  in  DATA_WIDTH  push data, sampled when wren==1.
- wren  in  1  push request, one entry per cycle.
- rden  in  1  pop request, one entry per cycle.
- rddata  out  DATA_WIDTH  registered pop data.
- data_valid  out  1  one-cycle pulse; rddata holds a popped entry.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow_err  out  1  sticky; set by a dropped push.
- underflow_err  out  1  sticky; set by a rejected pop.

Behaviour:
- Reset:
  - wr_ptr=0, rd_ptr=0, count=0, rddata=0, data_valid=0, overflow_err=0, underflow_err=0.
  - Outputs are therefore full=0, empty=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data. Any wren/rden in the reset cycle is ignored.
- full and empty are decoded combinationally from the registered count, so they reflect accesses one cycle after the accepting edge.
- Push acceptance:
  - Condition: wren && (!full || rd_accept).
  - On accept: mem[wr_ptr]<=wrdata, then wr_ptr increments and wraps from DEPTH-1 to 0.
- Pop acceptance:
  - Condition: rden && !empty.
  - On accept: rddata<=mem[rd_ptr], data_valid<=1, then rd_ptr increments and wraps.
  - Read latency is 1 cycle: the data appears the cycle after rden is sampled.
- data_valid is 0 in any cycle following a non-accepted or absent pop.
- rddata holds its last value when no pop is accepted.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both are accepted and count stays DEPTH.
  - When empty: the push is accepted, the pop is rejected (no write-through bypass), and the pop is an underflow.
  - Otherwise both are accepted.
- Overflow: wren while full with no accepted pop → data dropped, state unchanged, overflow_err<=1.
- Underflow: rden while empty → no pointer change, data_valid stays 0, underflow_err<=1.
- Error flags stay 1 until reset. They have no other clear mechanism.
- Ordering is strict first-in-first-out across pointer wrap-around.

Test Plan:
1. Underflow: reset, one rden pulse while empty → data_valid stays 0, empty=1, underflow_err=1 from the next cycle and stays 1 until reset.
2. Overflow: reset, push 0x00..0x20 (33 pushes, DEPTH=32) → full=1 after the 32nd push, the 33rd push is dropped, overflow_err=1, count stays 32. A subsequent drain returns 0x00..0x1F and 0x20 never appears.
3. Fill/drain ordering: reset, push 0x00..0x1F, then 32 single-cycle pops → rddata=0x00..0x1F in order, each with a one-cycle data_valid pulse one cycle after rden. empty=1 after the last pop. No error flags set.
4. Wrap-around: push 20, pop 20, push 32, pop 32 → order is preserved across the pointer wrap, and full/empty assert at the correct counts.
5. Simultaneous access:
   - When full, wren+rden for 4 cycles → full stays 1, no overflow_err, and the oldest data pops.
   - When empty, wren+rden → the write is stored, underflow_err=1, and count becomes 1.
6. Reset mid-operation: push 10, assert reset for 1 cycle → empty=1, full=0, data_valid=0, errors=0. A following pop sets underflow_err.
